// File: rtl/mcm_tap_sequencer.sv
// Two-requester, time-multiplexed 4-tap filter controller that drives one shared
// constant multiplier, accumulates the selected products, then rounds, shifts and clips.
module mcm_tap_sequencer #(
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned SHIFT   = 6,
  parameter logic [7:0]  TAP_SEL = 8'hE4,
  parameter logic [3:0]  TAP_NEG = 4'b0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [31:0]        req0_refs,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [31:0]        req1_refs,
  output logic [7:0]         mcm_x,
  input  logic signed [15:0] mcm_y1,
  input  logic signed [15:0] mcm_y2,
  input  logic signed [15:0] mcm_y3,
  input  logic signed [15:0] mcm_y4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic signed [ACC_W:0] ROUND = (ACC_W+1)'(1) << (SHIFT - 1);

  state_t                  state_q, state_d;
  logic [1:0]              tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [31:0]             buf_q, buf_d;
  logic                    last_grant_q, last_grant_d;
  logic                    out_valid_q, out_valid_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_id_q, out_id_d;

  logic                    grant0, grant1;
  logic [7:0]              ref_byte [4];
  logic [1:0]              sel;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext, acc_sum;
  logic signed [ACC_W:0]   rounded, shifted;
  logic [7:0]              clipped;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ref
      assign ref_byte[gi] = buf_q[8*gi +: 8];
    end
  endgenerate

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mcm_x      = (state_q == S_RUN) ? ref_byte[tap_q] : 8'd0;

  always_comb begin
    sel = TAP_SEL[{tap_q, 1'b0} +: 2];
    case (sel)
      2'd0:    prod = mcm_y1;
      2'd1:    prod = mcm_y2;
      2'd2:    prod = mcm_y3;
      default: prod = mcm_y4;
    endcase
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    acc_sum  = TAP_NEG[tap_q] ? (acc_q - prod_ext) : (acc_q + prod_ext);
    // One guard bit keeps the rounding add from wrapping near full scale.
    rounded  = {acc_sum[ACC_W-1], acc_sum} + ROUND;
    shifted  = rounded >>> SHIFT;
    if (shifted[ACC_W]) begin
      clipped = 8'd0;
    end else if (|shifted[ACC_W-1:8]) begin
      clipped = 8'hFF;
    end else begin
      clipped = shifted[7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    buf_d        = buf_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          buf_d        = grant1 ? req1_refs : req0_refs;
          last_grant_d = grant1;
          tap_d        = 2'd0;
          acc_d        = '0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        tap_d = tap_q + 2'd1;
        if (tap_q == 2'd3) begin
          out_data_d  = clipped;
          out_valid_d = 1'b1;
          out_id_d    = last_grant_q;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tap_q        <= 2'd0;
      acc_q        <= '0;
      buf_q        <= '0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'd0;
      out_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      buf_q        <= buf_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_mcm_tap_sequencer.sv
// Self-checking bench for mcm_tap_sequencer: table vectors, corner-case sequences and
// randomized groups checked against a plain-arithmetic filter and arbitration model.
module tb_mcm_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]        req0_refs, req1_refs;
  logic [7:0]         mcm_x;
  logic signed [15:0] mcm_y1, mcm_y2, mcm_y3, mcm_y4;
  logic               out_valid, out_ready, out_id;
  logic [7:0]         out_data;

  // second instance with taps 0 and 2 subtracted
  logic               n_req0_valid, n_req0_ready, n_req1_valid, n_req1_ready;
  logic [31:0]        n_req0_refs, n_req1_refs;
  logic [7:0]         n_mcm_x;
  logic signed [15:0] n_mcm_y1, n_mcm_y2, n_mcm_y3, n_mcm_y4;
  logic               n_out_valid, n_out_ready, n_out_id;
  logic [7:0]         n_out_data;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  hs0 = 0, hs1 = 0;
  int  txn_no = 0;
  logic model_last;

  // Shared multiplier: Y1..Y4 = x * {-4, 50, 85, -12}
  function automatic int coef(input int v);
    case (v)
      0:       return -4;
      1:       return 50;
      2:       return 85;
      default: return -12;
    endcase
  endfunction

  function automatic logic signed [15:0] mul(input logic [7:0] x, input int v);
    int p;
    p = int'(x) * coef(v);
    return 16'(p);
  endfunction

  assign mcm_y1   = mul(mcm_x, 0);
  assign mcm_y2   = mul(mcm_x, 1);
  assign mcm_y3   = mul(mcm_x, 2);
  assign mcm_y4   = mul(mcm_x, 3);
  assign n_mcm_y1 = mul(n_mcm_x, 0);
  assign n_mcm_y2 = mul(n_mcm_x, 1);
  assign n_mcm_y3 = mul(n_mcm_x, 2);
  assign n_mcm_y4 = mul(n_mcm_x, 3);

  mcm_tap_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_refs(req0_refs),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_refs(req1_refs),
    .mcm_x(mcm_x), .mcm_y1(mcm_y1), .mcm_y2(mcm_y2), .mcm_y3(mcm_y3), .mcm_y4(mcm_y4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  mcm_tap_sequencer #(.TAP_NEG(4'b0101)) u_neg (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(n_req0_valid), .req0_ready(n_req0_ready), .req0_refs(n_req0_refs),
    .req1_valid(n_req1_valid), .req1_ready(n_req1_ready), .req1_refs(n_req1_refs),
    .mcm_x(n_mcm_x), .mcm_y1(n_mcm_y1), .mcm_y2(n_mcm_y2), .mcm_y3(n_mcm_y3), .mcm_y4(n_mcm_y4),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_id(n_out_id)
  );

  always @(posedge clk) begin
    if (req0_valid && req0_ready) hs0 <= hs0 + 1;
    if (req1_valid && req1_ready) hs1 <= hs1 + 1;
  end

  // Reference: weighted sum, round half up, floor shift by 6, clip to 0..255.
  function automatic int model_out(input logic [31:0] refs, input logic [3:0] neg);
    int acc, p, r;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      p = int'(refs[8*k +: 8]) * coef(k);
      acc = neg[k] ? acc - p : acc + p;
    end
    r = (acc + 32) >>> 6;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Called and returns at a falling edge with the DUT idle.
  task automatic run_txn(input logic v0, input logic [31:0] r0, input logic v1,
                         input logic [31:0] r1, input int stall, input bit keep, input int exp_in);
    logic        exp_id;
    logic [31:0] g;
    int          exp, h0, h1;
    bit          ok;
    exp_id     = (v0 && v1) ? ~model_last : v1;
    model_last = exp_id;
    g          = exp_id ? r1 : r0;
    exp        = (exp_in < 0) ? model_out(g, 4'b0000) : exp_in;
    h0 = hs0; h1 = hs1;
    req0_valid = v0; req0_refs = r0; req1_valid = v1; req1_refs = r1;
    out_ready  = (stall == 0);
    #1;
    check("grant_ready", {req1_ready, req0_ready}, exp_id ? 2 : 1);
    @(posedge clk); #1;
    if (!keep) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_refs = $urandom; req1_refs = $urandom;
    end
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mcm_x !== g[8*k +: 8] || out_valid !== 1'b0 || req0_ready || req1_ready) ok = 1'b0;
    end
    check("run_mcm_x", ok, 1);
    @(negedge clk);
    check("out_valid", out_valid, 1);
    check("out_data", out_data, exp);
    check("out_id", out_id, exp_id);
    if (stall > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        if (!(out_valid === 1'b1 && out_data == 8'(exp) && out_id == exp_id &&
              !req0_ready && !req1_ready && mcm_x == 8'd0)) ok = 1'b0;
        @(negedge clk);
      end
      check("stall_hold", ok, 1);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_clear", out_valid, 0);
    check("one_ready", ((hs0 - h0) == (exp_id ? 0 : 1)) && ((hs1 - h1) == (exp_id ? 1 : 0)), 1);
    if (!keep) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    $display("txn %0d: id=%0d refs=%08h data=%0d expected=%0d stall=%0d",
             txn_no, out_id_last(exp_id), g, out_data, exp, stall);
    txn_no++;
  endtask

  function automatic int out_id_last(input logic id);
    return int'(id);
  endfunction

  task automatic run_neg(input logic [31:0] refs, input int exp);
    n_req0_valid = 1'b1; n_req0_refs = refs;
    @(posedge clk); #1;
    n_req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("neg_valid", n_out_valid, 1);
    check("neg_data", n_out_data, exp);
    check("neg_id", n_out_id, 0);
    @(negedge clk);
    check("neg_clear", n_out_valid, 0);
    $display("txn %0d: neg refs=%08h data=%0d expected=%0d", txn_no, refs, n_out_data, exp);
    txn_no++;
  endtask

  typedef struct {
    logic [31:0] refs;
    logic        who;
    int          exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit ok;
    vecs[0] = '{32'h40404040, 1'b0, 119};
    vecs[1] = '{32'hFFFFFFFF, 1'b1, 255};
    vecs[2] = '{32'h00000000, 1'b0, 0};
    vecs[3] = '{32'h281E140A, 1'b1, 47};
    vecs[4] = '{32'hFF0000C8, 1'b0, 0};
    vecs[5] = '{32'h00010000, 1'b1, 1};
    vecs[6] = '{32'h000000FF, 1'b0, 0};

    rst_n = 1'b0; model_last = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_refs = '0; req1_refs = '0; out_ready = 1'b0;
    n_req0_valid = 1'b0; n_req1_valid = 1'b0; n_req0_refs = '0; n_req1_refs = '0; n_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_mcm_x", mcm_x, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", {req1_ready, req0_ready}, 0);

    // both held valid: alternating grants, req0 first
    for (int i = 0; i < 4; i++) run_txn(1'b1, 32'h281E140A, 1'b1, 32'h01020304, 0, 1'b1, -1);

    run_neg(32'h64646464, 0);
    run_neg(32'h64006400, 59);

    for (int i = 0; i < 7; i++)
      run_txn(!vecs[i].who, vecs[i].refs, vecs[i].who, vecs[i].refs, 0, 1'b0, vecs[i].exp);

    run_txn(1'b1, 32'h40404040, 1'b0, 32'h0, 10, 1'b0, 119);

    for (int i = 0; i < 20; i++) begin
      int v;
      v = $urandom_range(1, 3);
      run_txn(v[0], $urandom, v[1], $urandom, $urandom_range(0, 3), 1'b0, -1);
    end

    // reset in the middle of a group
    run_txn(1'b0, 32'h0, 1'b1, 32'h40404040, 0, 1'b0, 119);
    req0_valid = 1'b1; req0_refs = 32'h11223344;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    check("abort_tap2_mcm_x", mcm_x, 8'h22);
    rst_n = 1'b0;
    #1;
    check("abort_mcm_x", mcm_x, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_id", out_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("abort_no_output", ok, 1);
    model_last = 1'b1;
    run_txn(1'b1, 32'h0A0B0C0D, 1'b1, 32'hA0B0C0D0, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
